// File: rtl/osd_blender.sv
// Alpha-blends an OSD layer over live video with a per-frame global fade.
// Video is delayed to meet the OSD generator, then a two-stage multiply pipeline mixes them.
`timescale 1ns/1ps
module osd_blender #(
  parameter int unsigned OSD_LAT   = 1,
  parameter int unsigned FADE_STEP = 16
) (
  input  logic       vclk,
  input  logic       rst_i,
  input  logic [7:0] vid_r,
  input  logic [7:0] vid_g,
  input  logic [7:0] vid_b,
  input  logic       vid_hs,
  input  logic       vid_vs,
  input  logic       vid_de,
  input  logic [7:0] osd_alpha,
  input  logic [7:0] osd_red,
  input  logic [7:0] osd_green,
  input  logic [7:0] osd_blue,
  input  logic       osd_enable,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic       out_hs,
  output logic       out_vs,
  output logic       out_de,
  output logic       fade_busy,
  output logic       osd_visible
);

  localparam int unsigned VidW = 27;
  localparam logic [8:0]  Step = 9'(FADE_STEP);

  typedef enum logic [1:0] {StOff, StFadeIn, StOn, StFadeOut} state_e;

  // Packed video word: {r, g, b, hs, vs, de}
  logic [VidW-1:0] vid_in, vid_dly;
  assign vid_in = {vid_r, vid_g, vid_b, vid_hs, vid_vs, vid_de};

  generate
    if (OSD_LAT == 0) begin : g_no_dly
      assign vid_dly = vid_in;
    end else begin : g_dly
      logic [VidW-1:0] dly_q [OSD_LAT];
      always_ff @(posedge vclk or posedge rst_i) begin
        if (rst_i) begin
          for (int unsigned i = 0; i < OSD_LAT; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= vid_in;
          for (int unsigned i = 1; i < OSD_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign vid_dly = dly_q[OSD_LAT-1];
    end
  endgenerate

  // Fade state and global alpha
  state_e     state_q, state_d;
  logic [7:0] g_q, g_d, g_up, g_dn;
  logic [8:0] g_sum;
  logic       vs_prev_q, tick;

  assign tick  = vid_vs & ~vs_prev_q;
  assign g_sum = {1'b0, g_q} + Step;
  assign g_up  = g_sum[8] ? 8'hFF : g_sum[7:0];
  assign g_dn  = ({1'b0, g_q} > Step) ? (g_q - Step[7:0]) : 8'h00;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    if (tick) begin
      unique case (state_q)
        StOff: begin
          if (osd_enable) begin
            g_d     = g_up;
            state_d = (g_up == 8'hFF) ? StOn : StFadeIn;
          end
        end
        StOn: begin
          if (!osd_enable) begin
            g_d     = g_dn;
            state_d = (g_dn == 8'h00) ? StOff : StFadeOut;
          end
        end
        StFadeIn, StFadeOut: begin
          if (osd_enable) begin
            g_d     = g_up;
            state_d = (g_up == 8'hFF) ? StOn : StFadeIn;
          end else begin
            g_d     = g_dn;
            state_d = (g_dn == 8'h00) ? StOff : StFadeOut;
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  always_ff @(posedge vclk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StOff;
      g_q         <= 8'h00;
      vs_prev_q   <= 1'b0;
      fade_busy   <= 1'b0;
      osd_visible <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      vs_prev_q   <= vid_vs;
      fade_busy   <= (state_q == StFadeIn) || (state_q == StFadeOut);
      osd_visible <= (g_q != 8'h00);
    end
  end

  // Stage 1: scale OSD alpha by global alpha; 255 is stretched to 256 so full-on is exact
  logic [8:0]      gs;
  logic [7:0]      a_eff_d, a_eff_q;
  logic [23:0]     osd_q;
  logic [VidW-1:0] vid_s1_q;

  assign gs      = {1'b0, g_q} + {8'b0, g_q[7]};
  assign a_eff_d = 8'(({8'b0, osd_alpha} * {7'b0, gs}) >> 8);

  always_ff @(posedge vclk or posedge rst_i) begin
    if (rst_i) begin
      a_eff_q  <= 8'h00;
      osd_q    <= 24'h0;
      vid_s1_q <= '0;
    end else begin
      a_eff_q  <= a_eff_d;
      osd_q    <= {osd_red, osd_green, osd_blue};
      vid_s1_q <= vid_dly;
    end
  end

  // Stage 2: per-channel mix with k in 0..256 so both endpoints pass through untouched
  logic [8:0] k;
  assign k = {1'b0, a_eff_q} + {8'b0, a_eff_q[7]};

  function automatic logic [7:0] blend(input logic [7:0] o, input logic [7:0] v,
                                       input logic [8:0] kk);
    return 8'(({9'b0, o} * {8'b0, kk} + {9'b0, v} * (17'd256 - {8'b0, kk})) >> 8);
  endfunction

  always_ff @(posedge vclk or posedge rst_i) begin
    if (rst_i) begin
      out_r  <= 8'h00;
      out_g  <= 8'h00;
      out_b  <= 8'h00;
      out_hs <= 1'b0;
      out_vs <= 1'b0;
      out_de <= 1'b0;
    end else begin
      out_hs <= vid_s1_q[2];
      out_vs <= vid_s1_q[1];
      out_de <= vid_s1_q[0];
      if (vid_s1_q[0]) begin
        out_r <= blend(osd_q[23:16], vid_s1_q[26:19], k);
        out_g <= blend(osd_q[15:8],  vid_s1_q[18:11], k);
        out_b <= blend(osd_q[7:0],   vid_s1_q[10:3],  k);
      end else begin
        out_r <= 8'h00;
        out_g <= 8'h00;
        out_b <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_osd_blender.sv
// Bench for osd_blender: directed fade/blend scenarios plus random frames against a
// history-based reference model (global alpha walks up/down by FADE_STEP on each vsync rise).
`timescale 1ns/1ps
module tb_osd_blender;

  localparam int Lat   = 1;
  localparam int Step  = 100;
  localparam int HistN = 8192;

  logic       vclk, rst_i;
  logic [7:0] vid_r, vid_g, vid_b, osd_alpha, osd_red, osd_green, osd_blue;
  logic       vid_hs, vid_vs, vid_de, osd_enable;
  logic [7:0] out_r, out_g, out_b;
  logic       out_hs, out_vs, out_de, fade_busy, osd_visible;

  osd_blender #(.OSD_LAT(Lat), .FADE_STEP(Step)) dut (
    .vclk(vclk), .rst_i(rst_i),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
    .osd_alpha(osd_alpha), .osd_red(osd_red), .osd_green(osd_green), .osd_blue(osd_blue),
    .osd_enable(osd_enable),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
    .fade_busy(fade_busy), .osd_visible(osd_visible)
  );

  initial begin
    vclk = 1'b0;
    forever #5 vclk = ~vclk;
  end

  int checks = 0, passed = 0, n = 0, rst_edge = 0;
  bit [7:0] vr_h[HistN], vg_h[HistN], vb_h[HistN];
  bit [7:0] oa_h[HistN], or_h[HistN], og_h[HistN], ob_h[HistN];
  bit       hs_h[HistN], vs_h[HistN], de_h[HistN];
  int       g_h[HistN];

  logic [26:0] act_pix, exp_pix;
  logic [1:0]  exp_st;
  int          frm_bad;
  logic [28:0] bad_act, bad_exp;
  logic [23:0] fx_v, fx_o;
  logic [7:0]  fx_a;

  assign act_pix = {out_r, out_g, out_b, out_hs, out_vs, out_de};

  function automatic int gval(input int i);
    if (i <= rst_edge || i < 0) return 0;
    return g_h[i];
  endfunction

  function automatic int mix(input int o, input int v, input int k);
    return (o * k + v * (256 - k)) / 256;
  endfunction

  // Advance one clock, log sampled inputs, update the model and predict the outputs.
  task automatic step();
    int gp, g, iv, io, gs, a, k;
    bit vp;
    @(posedge vclk);
    n++;
    vr_h[n] = vid_r; vg_h[n] = vid_g; vb_h[n] = vid_b;
    oa_h[n] = osd_alpha; or_h[n] = osd_red; og_h[n] = osd_green; ob_h[n] = osd_blue;
    hs_h[n] = vid_hs; vs_h[n] = vid_vs; de_h[n] = vid_de;
    if (rst_i) begin
      rst_edge = n;
      g_h[n]   = 0;
    end else begin
      gp = gval(n - 1);
      vp = (n - 1 > rst_edge) ? vs_h[n-1] : 1'b0;
      g  = gp;
      if (vid_vs && !vp)
        g = osd_enable ? ((gp + Step > 255) ? 255 : gp + Step) : ((gp < Step) ? 0 : gp - Step);
      g_h[n] = g;
    end
    iv = n - Lat - 1;
    io = n - 1;
    if (iv <= rst_edge) begin
      exp_pix = '0;
    end else begin
      g  = gval(n - 2);
      gs = g + ((g >= 128) ? 1 : 0);
      a  = (int'(oa_h[io]) * gs) / 256;
      k  = a + ((a >= 128) ? 1 : 0);
      if (de_h[iv])
        exp_pix = {8'(mix(or_h[io], vr_h[iv], k)), 8'(mix(og_h[io], vg_h[iv], k)),
                   8'(mix(ob_h[io], vb_h[iv], k)), hs_h[iv], vs_h[iv], 1'b1};
      else
        exp_pix = {24'h0, hs_h[iv], vs_h[iv], 1'b0};
    end
    g = gval(n - 1);
    exp_st = {(g > 0 && g < 255), (g != 0)};
    #1;
  endtask

  task automatic drive(input logic [23:0] v, input logic hs, input logic vs, input logic de,
                       input logic [7:0] a, input logic [23:0] o, input logic en);
    {vid_r, vid_g, vid_b} = v;
    vid_hs = hs; vid_vs = vs; vid_de = de;
    osd_alpha = a;
    {osd_red, osd_green, osd_blue} = o;
    osd_enable = en;
  endtask

  // One frame: vsync high for 2 cycles, de from cycle 3; enable may differ mid-frame.
  task automatic run_frame(input int len, input bit en_tick, input bit en_mid, input bit rnd);
    int sel;
    frm_bad = 0;
    for (int i = 0; i < len; i++) begin
      if (rnd) begin
        {vid_r, vid_g, vid_b} = 24'($urandom);
        {osd_red, osd_green, osd_blue} = 24'($urandom);
        sel = $urandom_range(0, 3);
        osd_alpha = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      end else begin
        {vid_r, vid_g, vid_b} = fx_v;
        {osd_red, osd_green, osd_blue} = fx_o;
        osd_alpha = fx_a;
      end
      vid_vs = (i < 2);
      vid_hs = (i % 5 == 0);
      vid_de = (i >= 3);
      osd_enable = (i >= 4 && i < len - 3) ? en_mid : en_tick;
      step();
      if (act_pix !== exp_pix || {fade_busy, osd_visible} !== exp_st) begin
        if (frm_bad == 0) begin
          bad_act = {act_pix, fade_busy, osd_visible};
          bad_exp = {exp_pix, exp_st};
        end
        frm_bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(24'h0, 0, 0, 0, 8'h00, 24'h0, 0);
    step();
    step();
    checks++;
    if ({act_pix, fade_busy, osd_visible} !== 29'h0)
      $display("FAIL reset_state: got %h want 0", {act_pix, fade_busy, osd_visible});
    else passed++;
    rst_i = 1'b0;
  endtask

  task automatic test_latency();
    drive(24'h123456, 0, 0, 1, 8'hFF, 24'h0, 0);
    step();
    drive(24'h0, 0, 0, 0, 8'h00, 24'h0, 0);
    step();
    checks++;
    if (out_de !== 1'b0) $display("FAIL latency_early_de: got %b want 0", out_de);
    else passed++;
    step();
    checks++;
    if ({out_r, out_g, out_b, out_de} !== {24'h123456, 1'b1})
      $display("FAIL latency_pixel: got %h want %h", {out_r, out_g, out_b, out_de},
               {24'h123456, 1'b1});
    else passed++;
    checks++;
    if (act_pix !== exp_pix) $display("FAIL latency_model: got %h want %h", act_pix, exp_pix);
    else passed++;
  endtask

  task automatic test_midframe();
    fx_v = 24'h0; fx_o = 24'hFFFFFF; fx_a = 8'hFF;
    run_frame(16, 0, 1, 0);
    run_frame(16, 0, 0, 0);
    checks++;
    if (frm_bad !== 0) $display("FAIL midframe_frames: got %h want %h", bad_act, bad_exp);
    else passed++;
    checks++;
    if ({fade_busy, osd_visible} !== 2'b00)
      $display("FAIL midframe_state: got %b want 00", {fade_busy, osd_visible});
    else passed++;
  endtask

  task automatic test_fade();
    bit          en_t [11]  = '{1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    logic [1:0]  want_st [11] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00,
                                  2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    logic [7:0]  want_px [11] = '{8'h62, 8'hC8, 8'hFF, 8'h9B, 8'h35, 8'h00,
                                  8'h62, 8'hC8, 8'h62, 8'h00, 8'h00};
    fx_v = 24'h0; fx_o = 24'hFFFFFF; fx_a = 8'hFF;
    for (int f = 0; f < 11; f++) begin
      run_frame(16, en_t[f], en_t[f], 0);
      checks++;
      if (frm_bad !== 0) $display("FAIL fade_frame%0d: got %h want %h", f, bad_act, bad_exp);
      else passed++;
      checks++;
      if ({fade_busy, osd_visible} !== want_st[f])
        $display("FAIL fade_status%0d: got %b want %b", f, {fade_busy, osd_visible},
                 want_st[f]);
      else passed++;
      checks++;
      if ({out_r, out_g, out_b} !== {3{want_px[f]}})
        $display("FAIL fade_pixel%0d: got %h want %h", f, {out_r, out_g, out_b},
                 {3{want_px[f]}});
      else passed++;
    end
  endtask

  task automatic test_blend();
    logic [23:0] vv [4] = '{24'h0, 24'h112233, 24'h112233, 24'h000000};
    logic [23:0] oo [4] = '{24'hFFFFFF, 24'hAA00FF, 24'hAA00FF, 24'hFFFFFF};
    logic [7:0]  aa [4] = '{8'hFF, 8'hFF, 8'h00, 8'h80};
    logic [23:0] want [4] = '{24'hFFFFFF, 24'hAA00FF, 24'h112233, 24'h808080};
    // Frames 0..2 bring the fade to ON; the later frames stay ON.
    for (int f = 0; f < 6; f++) begin
      fx_v = vv[(f < 3) ? 0 : f - 2]; fx_o = oo[(f < 3) ? 0 : f - 2];
      fx_a = aa[(f < 3) ? 0 : f - 2];
      run_frame(16, 1, 1, 0);
      checks++;
      if (frm_bad !== 0) $display("FAIL blend_frame%0d: got %h want %h", f, bad_act, bad_exp);
      else passed++;
      if (f >= 2) begin
        checks++;
        if ({out_r, out_g, out_b} !== want[f-2])
          $display("FAIL blend_pixel%0d: got %h want %h", f, {out_r, out_g, out_b}, want[f-2]);
        else passed++;
      end
    end
    for (int f = 0; f < 3; f++) run_frame(16, 0, 0, 0);
    checks++;
    if (osd_visible !== 1'b0) $display("FAIL blend_fadeout: got %b want 0", osd_visible);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    fx_v = 24'h0; fx_o = 24'hFFFFFF; fx_a = 8'hFF;
    run_frame(16, 1, 1, 0);
    checks++;
    if ({fade_busy, osd_visible} !== 2'b11)
      $display("FAIL rstmid_pre: got %b want 11", {fade_busy, osd_visible});
    else passed++;
    drive(24'h445566, 0, 0, 1, 8'hFF, 24'hFFFFFF, 1);
    step();
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({act_pix, fade_busy, osd_visible} !== 29'h0)
      $display("FAIL rstmid_async: got %h want 0", {act_pix, fade_busy, osd_visible});
    else passed++;
    step();
    rst_i = 1'b0;
    drive(24'h5A6B7C, 0, 0, 1, 8'hFF, 24'hFFFFFF, 1);
    step();
    drive(24'h0, 0, 0, 0, 8'hFF, 24'hFFFFFF, 1);
    step();
    step();
    checks++;
    if ({out_r, out_g, out_b, out_de, fade_busy, osd_visible} !== {24'h5A6B7C, 3'b100})
      $display("FAIL rstmid_video: got %h want %h",
               {out_r, out_g, out_b, out_de, fade_busy, osd_visible}, {24'h5A6B7C, 3'b100});
    else passed++;
    run_frame(16, 1, 1, 0);
    checks++;
    if ({out_r, out_g, out_b, osd_visible} !== {24'h626262, 1'b1})
      $display("FAIL rstmid_first_tick: got %h want %h", {out_r, out_g, out_b, osd_visible},
               {24'h626262, 1'b1});
    else passed++;
  endtask

  task automatic test_random();
    for (int f = 0; f < 16; f++) begin
      run_frame($urandom_range(10, 30), 1'($urandom), 1'($urandom), 1);
      checks++;
      if (frm_bad !== 0) $display("FAIL random_frame%0d: got %h want %h", f, bad_act, bad_exp);
      else passed++;
    end
  endtask

  initial begin
    rst_i = 1'b1;
    drive(24'h0, 0, 0, 0, 8'h00, 24'h0, 0);
    test_reset();
    test_latency();
    test_midframe();
    test_fade();
    test_blend();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
